// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operator encodings, flag bit positions and the
// unpacked-operand record produced by the unpack stage.
`timescale 1ns/1ps
package fpu_pkg;

  localparam int FPU_EXP_W = 8;
  localparam int FPU_MAN_W = 23;

  typedef enum logic [1:0] {
    FPU_OP_ADD = 2'b00,
    FPU_OP_SUB = 2'b01,
    FPU_OP_MUL = 2'b10,
    FPU_OP_DIV = 2'b11
  } fpu_op_e;

  // Bit positions inside the 3-bit {nan, inf, zero} flag vector.
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  // Unpacked operand: mantissa carries the hidden bit in its MSB.
  typedef struct packed {
    logic                 sign;
    logic [FPU_EXP_W-1:0] exponent;
    logic [FPU_MAN_W:0]   mantissa;
    logic [2:0]           flags;
  } fpu_operand_t;

endpackage

// File: rtl/fpu_unpack_stage_if.sv
// Handshake and payload bundle of the operand-unpack stage. The slave
// modport is the stage itself; the master modport is its environment.
`timescale 1ns/1ps
interface fpu_unpack_stage_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_operand_a;
  logic [W-1:0]     in_operand_b;
  logic [1:0]       in_operator;

  logic             out_valid;
  logic             out_ready;
  logic             sign_1;
  logic             sign_2;
  logic [EXP_W-1:0] exponent_1;
  logic [EXP_W-1:0] exponent_2;
  logic [MAN_W:0]   mantissa_1;
  logic [MAN_W:0]   mantissa_2;
  logic [EXP_W-1:0] exp_diff;
  logic [2:0]       flags_1;
  logic [2:0]       flags_2;
  logic             swapped;
  logic [1:0]       operator;

  modport master (
    output in_valid, in_operand_a, in_operand_b, in_operator, out_ready,
    input  in_ready, out_valid, sign_1, sign_2, exponent_1, exponent_2,
           mantissa_1, mantissa_2, exp_diff, flags_1, flags_2, swapped, operator
  );

  modport slave (
    input  in_valid, in_operand_a, in_operand_b, in_operator, out_ready,
    output in_ready, out_valid, sign_1, sign_2, exponent_1, exponent_2,
           mantissa_1, mantissa_2, exp_diff, flags_1, flags_2, swapped, operator
  );
endinterface

// File: rtl/fpu_operand_classify.sv
// Combinational classifier for one packed operand: sign, effective exponent,
// {hidden, fraction} mantissa and {nan, inf, zero} flags.
// FPU_UNPACK_SUBNORMAL_EN defined keeps subnormals (exponent 1, hidden 0);
// otherwise subnormals flush to a signed zero.
`timescale 1ns/1ps
module fpu_operand_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = FPU_EXP_W,
  parameter int MAN_W = FPU_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] operand,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [MAN_W:0]       mantissa,
  output logic [2:0]           flags
);

  logic [EXP_W-1:0] raw_exp;
  logic [MAN_W-1:0] raw_frac;
  logic             exp_ones;
  logic             exp_zero;
  logic             frac_zero;

  assign raw_exp   = operand[EXP_W+MAN_W-1:MAN_W];
  assign raw_frac  = operand[MAN_W-1:0];
  assign exp_ones  = &raw_exp;
  assign exp_zero  = ~|raw_exp;
  assign frac_zero = ~|raw_frac;

  // Decode the operand class and form the effective fields.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sign     = operand[EXP_W+MAN_W];
    exponent = raw_exp;
    mantissa = {1'b1, raw_frac};
    flags    = '0;
    if (exp_ones) begin
      if (frac_zero) flags[FLAG_INF] = 1'b1;
      else           flags[FLAG_NAN] = 1'b1;
    end else if (exp_zero) begin
      if (frac_zero) begin
        exponent        = '0;
        mantissa        = '0;
        flags[FLAG_ZERO] = 1'b1;
      end else begin
`ifdef FPU_UNPACK_SUBNORMAL_EN
        exponent = EXP_W'(1);
        mantissa = {1'b0, raw_frac};
`else
        exponent         = '0;
        mantissa         = '0;
        flags[FLAG_ZERO] = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/fpu_unpack_stage.sv
// Operand-unpack stage: classifies both operands, orders add/sub operands by
// magnitude, and registers the result behind a one-entry skid buffer so that
// in_ready comes straight from a flop. Subnormal handling follows
// FPU_UNPACK_SUBNORMAL_EN (see fpu_operand_classify).
`timescale 1ns/1ps
module fpu_unpack_stage
  import fpu_pkg::*;
#(
  parameter int EXP_W = FPU_EXP_W,
  parameter int MAN_W = FPU_MAN_W
) (
  input logic               clk,
  input logic               rst_n,
  fpu_unpack_stage_if.slave bus
);

  typedef struct packed {
    logic             sign_1;
    logic             sign_2;
    logic [EXP_W-1:0] exponent_1;
    logic [EXP_W-1:0] exponent_2;
    logic [MAN_W:0]   mantissa_1;
    logic [MAN_W:0]   mantissa_2;
    logic [EXP_W-1:0] exp_diff;
    logic [2:0]       flags_1;
    logic [2:0]       flags_2;
    logic             swapped;
    logic [1:0]       operator;
  } beat_t;

  logic             sign_a, sign_b, sign_b_eff;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   man_a, man_b;
  logic [2:0]       flags_a, flags_b;
  logic             add_sub, swap;

  beat_t next_beat, out_beat, skid_beat;
  logic  out_valid_q, skid_valid_q;
  logic  in_fire, out_fire, out_free;

  fpu_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_a (
    .operand(bus.in_operand_a), .sign(sign_a), .exponent(exp_a),
    .mantissa(man_a), .flags(flags_a)
  );

  fpu_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_b (
    .operand(bus.in_operand_b), .sign(sign_b), .exponent(exp_b),
    .mantissa(man_b), .flags(flags_b)
  );

  // Subtraction flips b's sign before ordering so it follows b into its slot.
  // Comparing {exponent, hidden, fraction} orders post-flush magnitudes the
  // same way as the raw {exp, frac} fields.
  assign add_sub    = (bus.in_operator == FPU_OP_ADD) || (bus.in_operator == FPU_OP_SUB);
  assign sign_b_eff = sign_b ^ (bus.in_operator == FPU_OP_SUB);
  assign swap       = add_sub && ({exp_b, man_b} > {exp_a, man_a});

  // Place operands into slots and compute the alignment shift.
  always_comb begin
    next_beat = '0;
    if (swap) begin
      next_beat.sign_1     = sign_b_eff;
      next_beat.exponent_1 = exp_b;
      next_beat.mantissa_1 = man_b;
      next_beat.flags_1    = flags_b;
      next_beat.sign_2     = sign_a;
      next_beat.exponent_2 = exp_a;
      next_beat.mantissa_2 = man_a;
      next_beat.flags_2    = flags_a;
    end else begin
      next_beat.sign_1     = sign_a;
      next_beat.exponent_1 = exp_a;
      next_beat.mantissa_1 = man_a;
      next_beat.flags_1    = flags_a;
      next_beat.sign_2     = sign_b_eff;
      next_beat.exponent_2 = exp_b;
      next_beat.mantissa_2 = man_b;
      next_beat.flags_2    = flags_b;
    end
    next_beat.exp_diff = add_sub ? (next_beat.exponent_1 - next_beat.exponent_2) : '0;
    next_beat.swapped  = swap;
    next_beat.operator = bus.in_operator;
  end

  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_fire = out_valid_q && bus.out_ready;
  assign out_free = out_fire || !out_valid_q;

  // Output and skid occupancy: refill the output from skid first, then from
  // the input; a beat arriving while the output is stalled parks in skid.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_beat     <= '0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_beat     <= skid_beat;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_beat    <= next_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Skid payload capture.
  always_ff @(posedge clk) begin
    // NOTE: payload has no reset; it is only ever read while skid_valid_q is set.
    if (!out_free && in_fire) skid_beat <= next_beat;
  end

  assign bus.in_ready   = !skid_valid_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sign_1     = out_beat.sign_1;
  assign bus.sign_2     = out_beat.sign_2;
  assign bus.exponent_1 = out_beat.exponent_1;
  assign bus.exponent_2 = out_beat.exponent_2;
  assign bus.mantissa_1 = out_beat.mantissa_1;
  assign bus.mantissa_2 = out_beat.mantissa_2;
  assign bus.exp_diff   = out_beat.exp_diff;
  assign bus.flags_1    = out_beat.flags_1;
  assign bus.flags_2    = out_beat.flags_2;
  assign bus.swapped    = out_beat.swapped;
  assign bus.operator   = out_beat.operator;

endmodule

// File: doc/fpu_unpack_stage.md
# fpu_unpack_stage

Parametrised operand-unpack stage at the head of the FPU pipeline. It accepts two packed IEEE-754-style operands and an operator over a valid/ready handshake. Per operand it classifies NaN, infinity, zero and subnormal, and forms effective exponents and mantissas with the hidden bit. For add/sub it orders the operands by magnitude and computes the alignment shift. A one-entry skid buffer keeps `in_ready` registered-only, so the stage tolerates stalls from the align/compute stages without dropping or duplicating beats.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; packed word W = 1+EXP_W+MAN_W
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept; driven only from the skid-occupancy register
- in_operand_a, in_operand_b  in  W  packed operands
- in_operator  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- sign_1, sign_2  out  1  operand signs (sign_2 effective, see Operation)
- exponent_1, exponent_2  out  EXP_W  effective exponents
- mantissa_1, mantissa_2  out  MAN_W+1  {hidden, fraction}
- exp_diff  out  EXP_W  exponent_1 − exponent_2
- flags_1, flags_2  out  3  {nan, inf, zero}
- swapped  out  1  operand b is in slot 1
- operator  out  2  registered in_operator

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Classification of each operand:
  - exp all-ones, frac≠0 → nan.
  - exp all-ones, frac=0 → inf.
  - exp=0, frac=0 → zero.
  - exp=0, frac≠0 → subnormal (see Configuration).
- Normal, inf and NaN operands: hidden=1, effective exponent = raw exponent.
- Zero operands: hidden=0, effective exponent 0, fraction 0.
- Sub: invert b's sign before any swap, so the flipped sign travels with b.
- Add/sub ordering: unsigned compare of {exp, frac} (EXP_W+MAN_W bits). If b > a, swap operands and set swapped=1. On a tie, keep a in slot 1.
- exp_diff is always ≥0 for add/sub.
- Mul/div: no swap; swapped=0, exp_diff=0, a in slot 1.
- Skid behaviour:
  - If the output register is full and not accepted while an input transfer occurs, the beat goes to the skid register and in_ready=0 the next cycle.
  - When the output is accepted and skid is full, skid moves to output the same edge and in_ready returns to 1 the next cycle.
  - Ordering is strictly FIFO.
- Simultaneous in and out transfer with skid empty: the new beat replaces the output register; out_valid stays 1.

## Timing
- Latency: 1 cycle from input transfer to out_valid when unstalled; throughput 1 beat/cycle.
- Reset (rst_n low at a clk edge) clears all output registers to 0 and clears skid occupancy, so in_ready reads 1.
- An input transfer coinciding with reset is discarded; reset wins.
- Reset mid-stream: pending output and skid beats are dropped; out_valid=0 after that edge.
- Output payload is stable while out_valid && !out_ready.

## Configuration
- FPU_UNPACK_SUBNORMAL_EN defined: a subnormal operand keeps its fraction, hidden=0, effective exponent=1, zero flag clear.
- Macro undefined (flush-to-zero): a subnormal is treated as a signed zero. Fraction forced 0, hidden=0, exponent 0, zero flag set, sign preserved.
- The magnitude compare uses post-flush values.

## Structure
- Shared package fpu_pkg holds:
  - operator encodings FPU_OP_ADD/SUB/MUL/DIV;
  - flag bit indices FLAG_NAN/INF/ZERO;
  - the unpacked-operand struct type {sign, exponent, mantissa, flags}, parametrised through localparams from EXP_W/MAN_W.
- Sub-module fpu_operand_classify: combinational; one packed operand → sign, effective exponent, mantissa, flags. Instantiated twice.
- Top level contains compare/swap, the output register and the skid register.

## Test plan
- Add 0x3F800000 + 0x40000000, out_ready=1 → next cycle out_valid=1, swapped=1, exponent_1=0x80, mantissa_1=0x800000, exponent_2=0x7F, exp_diff=1.
- Add 0x3F800000 + 0x3FC00000 (equal exponents) → swapped=1, mantissa_1=0xC00000, exp_diff=0. Sub 0x40400000 − 0x40400000 → swapped=0, sign_2=1.
- Mul 0x7F800000 × 0x7FC00000 → swapped=0, exp_diff=0, flags_1=3'b010, flags_2=3'b100, operator=2'b10.
- Add 0x00000001 + 0x00000000:
  - Macro defined → exponent_1=1, mantissa_1=0x000001, flags_1=0, exp_diff=1.
  - Macro undefined → both flags=3'b001, mantissas 0, exp_diff=0.
- Backpressure: hold out_ready=0, drive 3 consecutive valid beats → beat 1 in output, beat 2 in skid, in_ready=0 from the cycle after beat 2, beat 3 held. Then out_ready=1 → beats 1, 2, 3 emerge in order with no loss or duplication.
- Reset with output and skid both full: rst_n=0 for one edge → out_valid=0 and in_ready=1 after that edge; the next beat emerges with 1-cycle latency.
